// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: default boot address, fetch buffer depth,
// the buffered fetch entry layout and the fetch FSM states.
package rv32i_pkg;

   localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
   localparam int          FETCH_FIFO_DEPTH  = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      FETCH_BOOT,
      FETCH_RUN
   } fetch_state_e;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Synchronous instruction buffer between imem responses and decode.
// Clear wins over push/pop; push into a full buffer is allowed when the head pops.
module rv32i_fetch_fifo
   import rv32i_pkg::*;
#(
   parameter int DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  fetch_entry_t             data_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   output fetch_entry_t             data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr_q] <= data_i;
            wr_ptr_q      <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: credit-limited imem requests, in-order response tagging,
// flush redirection with discard of stale responses, and a decode-side buffer.
module rv32i_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
   parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        halt_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_instr_o,
   output logic [31:0] fetch_pc_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = CW + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   addr_q;
   logic [31:0]   resp_pc_q;
   logic [31:0]   flush_target;
   logic          req_hold_q;
   logic          armed_q;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] fifo_count;
   logic [DW-1:0] discard_q;
   logic          credit_ok;
   logic          grant;
   logic          flush_grant;
   logic          discard_resp;
   logic          live_resp;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   fetch_entry_t  push_entry;
   fetch_entry_t  head_entry;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FETCH_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_BOOT: state_d = FETCH_RUN;
         FETCH_RUN:  state_d = FETCH_RUN;
      endcase
   end

   // Credit covers buffered entries plus live in-flight requests, so every live response fits.
   assign credit_ok    = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW + 1)'(FIFO_DEPTH);
   assign instr_req_o  = (state_q == FETCH_RUN) && !flush_i && (req_hold_q || (!halt_i && credit_ok));
   assign instr_addr_o = addr_q;
   assign flush_target = flush_pc_i & 32'hFFFF_FFFC;

   assign grant        = instr_req_o && instr_gnt_i;
   assign flush_grant  = flush_i && instr_gnt_i && req_hold_q;
   assign discard_resp = instr_rvalid_i && (discard_q != '0);
   assign live_resp    = instr_rvalid_i && (discard_q == '0) && (outstanding_q != '0);
   assign pop          = fetch_valid_o && fetch_ready_i && !flush_i;
   assign push_entry   = '{pc: resp_pc_q, instr: instr_rdata_i};

   // A flush converts every live transaction into one whose response must be dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q        <= BOOT_ADDR;
         resp_pc_q     <= BOOT_ADDR;
         req_hold_q    <= 1'b0;
         armed_q       <= 1'b0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (flush_i) begin
         addr_q        <= flush_target;
         resp_pc_q     <= flush_target;
         req_hold_q    <= 1'b0;
         armed_q       <= armed_q | flush_grant;
         outstanding_q <= '0;
         discard_q     <= discard_q - DW'(discard_resp) + DW'(outstanding_q)
                          - DW'(live_resp) + DW'(flush_grant);
      end else begin
         if (grant) begin
            addr_q  <= addr_q + 32'd4;
            armed_q <= 1'b1;
         end
         if (live_resp) begin
            resp_pc_q <= resp_pc_q + 32'd4;
         end
         req_hold_q    <= instr_req_o && !instr_gnt_i;
         outstanding_q <= outstanding_q + CW'(grant) - CW'(live_resp);
         discard_q     <= discard_q - DW'(discard_resp);
      end
   end

   rv32i_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (live_resp && !flush_i),
      .data_i  (push_entry),
      .pop_i   (pop),
      .clear_i (flush_i),
      .data_o  (head_entry),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign fetch_valid_o = !fifo_empty;
   assign fetch_instr_o = head_entry.instr;
   assign fetch_pc_o    = head_entry.pc;

   // Responses before the first grant since reset belong to abandoned transactions.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(instr_rvalid_i && armed_q && outstanding_q == '0 && discard_q == '0));
         assert (!(live_resp && !flush_i && fifo_full && !pop));
      end
   end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with a small in-order imem responder model.
module tb_rv32i_fetch_unit;

   localparam logic [31:0] KEY = 32'hDEAD_BEEF;

   logic        clk_i;
   logic        rst_i;
   logic        instr_req_o;
   logic        instr_gnt_i;
   logic [31:0] instr_addr_o;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        halt_i;
   logic        fetch_valid_o;
   logic        fetch_ready_i;
   logic [31:0] fetch_instr_o;
   logic [31:0] fetch_pc_o;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          grants = 0;
   logic        auto_resp;
   logic [31:0] pending [$];
   logic [63:0] delivered [$];
   logic        s_req, s_valid, s_hs;
   logic [31:0] s_addr, s_pc, s_instr;

   rv32i_fetch_unit #(
      .BOOT_ADDR  (32'h0000_0000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .instr_req_o    (instr_req_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_addr_o   (instr_addr_o),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .flush_i        (flush_i),
      .flush_pc_i     (flush_pc_i),
      .halt_i         (halt_i),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_ready_i  (fetch_ready_i),
      .fetch_instr_o  (fetch_instr_o),
      .fetch_pc_o     (fetch_pc_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   function automatic logic [31:0] del_pc(input int i);
      if (i < delivered.size()) return delivered[i][63:32];
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] del_instr(input int i);
      if (i < delivered.size()) return delivered[i][31:0];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample on the falling edge, then update the imem model just after the rising edge.
   task automatic apply_cycle();
      @(negedge clk_i);
      s_req   = instr_req_o;
      s_addr  = instr_addr_o;
      s_valid = fetch_valid_o;
      s_pc    = fetch_pc_o;
      s_instr = fetch_instr_o;
      s_hs    = instr_req_o && instr_gnt_i && !rst_i;
      if (fetch_valid_o && fetch_ready_i && !flush_i && !rst_i)
         delivered.push_back({fetch_pc_o, fetch_instr_o});
      if (s_hs) grants++;
      @(posedge clk_i);
      #1;
      if (s_hs) pending.push_back(s_addr);
      if (auto_resp) begin
         if (pending.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = imem_word(pending.pop_front());
         end else begin
            instr_rvalid_i = 1'b0;
         end
      end
   endtask

   task automatic do_reset(input logic gnt, input logic autor, input logic ready);
      rst_i          = 1'b1;
      flush_i        = 1'b0;
      flush_pc_i     = 32'h0;
      halt_i         = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_gnt_i    = gnt;
      fetch_ready_i  = ready;
      auto_resp      = 1'b0;
      pending.delete();
      delivered.delete();
      apply_cycle();
      apply_cycle();
      auto_resp = autor;
      rst_i     = 1'b0;
      grants    = 0;
   endtask

   initial begin
      // Reset state and sustained streaming
      do_reset(1'b1, 1'b1, 1'b1);
      check_output("rst_req", 32'(s_req), 32'd0);
      check_output("rst_addr", s_addr, 32'h0);
      check_output("rst_valid", 32'(s_valid), 32'd0);
      check_output("rst_instr", s_instr, 32'h0);
      check_output("rst_pc", s_pc, 32'h0);
      apply_cycle();
      check_output("boot_no_req", 32'(s_req), 32'd0);
      apply_cycle();
      check_output("first_req", 32'(s_req), 32'd1);
      check_output("first_addr", s_addr, 32'h0);
      repeat (6) apply_cycle();
      check_output("stream_count", 32'(delivered.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check_output("stream_pc", del_pc(i), 32'(4 * i));
         check_output("stream_instr", del_instr(i), imem_word(32'(4 * i)));
      end

      // Decode stalled: credits stop fetching at four grants
      do_reset(1'b1, 1'b1, 1'b0);
      apply_cycle();
      repeat (12) apply_cycle();
      check_output("stall_grants", 32'(grants), 32'd4);
      check_output("stall_no_req", 32'(s_req), 32'd0);
      check_output("stall_valid", 32'(s_valid), 32'd1);
      check_output("stall_head_pc", s_pc, 32'h0);
      check_output("stall_head_instr", s_instr, imem_word(32'h0));
      fetch_ready_i = 1'b1;
      delivered.delete();
      apply_cycle();
      check_output("resume_pop_cycle_no_req", 32'(s_req), 32'd0);
      apply_cycle();
      check_output("resume_req", 32'(s_req), 32'd1);
      check_output("resume_addr", s_addr, 32'h10);
      repeat (3) apply_cycle();
      for (int i = 0; i < 5; i++) begin
         check_output("resume_pc", del_pc(i), 32'(4 * i));
      end

      // Flush with a non-empty buffer clears it
      flush_i    = 1'b1;
      flush_pc_i = 32'h0000_0402;
      delivered.delete();
      apply_cycle();
      flush_i = 1'b0;
      apply_cycle();
      check_output("flush_clear_valid", 32'(s_valid), 32'd0);
      check_output("flush_clear_req", 32'(s_req), 32'd1);
      check_output("flush_clear_addr", s_addr, 32'h400);
      repeat (4) apply_cycle();
      check_output("flush_clear_pc0", del_pc(0), 32'h400);
      check_output("flush_clear_instr0", del_instr(0), imem_word(32'h400));
      check_output("flush_clear_pc1", del_pc(1), 32'h404);

      // Flush with three outstanding requests
      do_reset(1'b1, 1'b0, 1'b1);
      repeat (4) apply_cycle();
      instr_gnt_i = 1'b0;
      flush_i     = 1'b1;
      flush_pc_i  = 32'h0000_0103;
      auto_resp   = 1'b1;
      apply_cycle();
      check_output("flush3_drop_req", 32'(s_req), 32'd0);
      flush_i     = 1'b0;
      instr_gnt_i = 1'b1;
      apply_cycle();
      check_output("flush3_req", 32'(s_req), 32'd1);
      check_output("flush3_addr", s_addr, 32'h100);
      repeat (5) apply_cycle();
      check_output("flush3_pc0", del_pc(0), 32'h100);
      check_output("flush3_instr0", del_instr(0), imem_word(32'h100));
      check_output("flush3_pc1", del_pc(1), 32'h104);

      // Flush coinciding with grant and response
      do_reset(1'b1, 1'b0, 1'b1);
      repeat (3) apply_cycle();
      auto_resp = 1'b1;
      apply_cycle();
      flush_i    = 1'b1;
      flush_pc_i = 32'h0000_0300;
      apply_cycle();
      check_output("flushrv_drop_req", 32'(s_req), 32'd0);
      flush_i = 1'b0;
      apply_cycle();
      check_output("flushrv_valid", 32'(s_valid), 32'd0);
      check_output("flushrv_req", 32'(s_req), 32'd1);
      check_output("flushrv_addr", s_addr, 32'h300);
      repeat (4) apply_cycle();
      check_output("flushrv_pc0", del_pc(0), 32'h300);
      check_output("flushrv_instr0", del_instr(0), imem_word(32'h300));
      check_output("flushrv_pc1", del_pc(1), 32'h304);

      // Halt during an ungranted request
      do_reset(1'b0, 1'b1, 1'b1);
      apply_cycle();
      apply_cycle();
      check_output("halt_pre_req", 32'(s_req), 32'd1);
      check_output("halt_pre_addr", s_addr, 32'h0);
      halt_i = 1'b1;
      repeat (5) begin
         apply_cycle();
         check_output("halt_hold_req", 32'(s_req), 32'd1);
         check_output("halt_hold_addr", s_addr, 32'h0);
      end
      instr_gnt_i = 1'b1;
      apply_cycle();
      check_output("halt_grant_req", 32'(s_req), 32'd1);
      check_output("halt_grant_count", 32'(grants), 32'd1);
      repeat (4) begin
         apply_cycle();
         check_output("halt_no_req", 32'(s_req), 32'd0);
      end
      check_output("halt_delivered", 32'(delivered.size()), 32'd1);
      check_output("halt_pc", del_pc(0), 32'h0);
      halt_i = 1'b0;
      apply_cycle();
      check_output("unhalt_req", 32'(s_req), 32'd1);
      check_output("unhalt_addr", s_addr, 32'h4);

      // Reset with two transactions in flight
      do_reset(1'b1, 1'b0, 1'b1);
      repeat (3) apply_cycle();
      rst_i = 1'b1;
      #1;
      check_output("async_reset_req", 32'(instr_req_o), 32'd0);
      apply_cycle();
      check_output("midrst_req", 32'(s_req), 32'd0);
      apply_cycle();
      rst_i          = 1'b0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'hBAD0_0000;
      apply_cycle();
      check_output("midrst_boot_req", 32'(s_req), 32'd0);
      instr_rdata_i = 32'hBAD0_0004;
      apply_cycle();
      check_output("midrst_req_after", 32'(s_req), 32'd1);
      check_output("midrst_addr", s_addr, 32'h0);
      instr_rvalid_i = 1'b0;
      pending.delete();
      delivered.delete();
      auto_resp   = 1'b1;
      instr_gnt_i = 1'b1;
      apply_cycle();
      check_output("midrst_late_ignored", 32'(s_valid), 32'd0);
      repeat (3) apply_cycle();
      check_output("midrst_pc0", del_pc(0), 32'h0);
      check_output("midrst_instr0", del_instr(0), imem_word(32'h0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
